imem_dmem_arbiter: RTL

// - Shares one single-port synchronous unified memory between the fetch port (IF) and the

---
 rtl/imem_dmem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and
// the load/store port; data has priority, a starvation counter guarantees fetch progress.
module imem_dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int BW = DW / 8;
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D_RD = 2'd2,
        RESP_D_WR = 2'd3
    } resp_e;

    resp_e          resp_own_r;
    resp_e          resp_own_s;
    logic [CW-1:0]  starve_cnt_r;
    logic [CW-1:0]  starve_cnt_s;
    logic           force_if_s;

    // Grant decision: data wins unless fetch has been starved for STARVE_MAX data grants.
    always_comb begin
        force_if_s = (starve_cnt_r == CNT_MAX);
        d_gnt      = rst & d_req & ~(force_if_s & if_req);
        if_gnt     = rst & if_req & ~d_gnt;
    end

    // Memory request mux; addresses are always presented word aligned.
    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_be    = {BW{1'b0}};
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        if (d_gnt) begin
            mem_addr  = {d_addr[AW-1:2], 2'b00};
            mem_be    = d_we ? d_be : {BW{1'b1}};
            mem_wdata = d_we ? d_wdata : {DW{1'b0}};
        end else if (if_gnt) begin
            mem_addr  = {if_addr[AW-1:2], 2'b00};
            mem_be    = {BW{1'b1}};
        end else begin
            mem_addr  = {AW{1'b0}};
        end
    end

    // Next response owner and starvation count, both derived from this cycle's grant.
    always_comb begin
        resp_own_s   = RESP_NONE;
        starve_cnt_s = starve_cnt_r;
        if (d_gnt) begin
            resp_own_s = d_we ? RESP_D_WR : RESP_D_RD;
        end else if (if_gnt) begin
            resp_own_s = RESP_IF;
        end else begin
            resp_own_s = RESP_NONE;
        end
        if (!if_req || if_gnt) begin
            starve_cnt_s = {CW{1'b0}};
        end else if (d_gnt && (starve_cnt_r != CNT_MAX)) begin
            starve_cnt_s = starve_cnt_r + CW'(1);
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_own_r   <= RESP_NONE;
            starve_cnt_r <= {CW{1'b0}};
        end else begin
            resp_own_r   <= resp_own_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

    // Response steering; gating with rst drops a response whose cycle falls inside reset.
    always_comb begin
        if_rvalid = rst & (resp_own_r == RESP_IF);
        d_rvalid  = rst & ((resp_own_r == RESP_D_RD) || (resp_own_r == RESP_D_WR));
        if_rdata  = {DW{1'b0}};
        d_rdata   = {DW{1'b0}};
        if (rst && (resp_own_r == RESP_IF)) begin
            if_rdata = mem_rdata;
        end else if (rst && (resp_own_r == RESP_D_RD)) begin
            d_rdata  = mem_rdata;
        end else begin
            if_rdata = {DW{1'b0}};
        end
    end

endmodule
